// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, saturation limits and FSM state type for the Q15.16 multiply-accumulate engine.
package mac_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int PROD_W = 64;
  localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
endpackage

// File: rtl/q15_16_mul.sv
// q15_16_mul: registered signed 32x32->64 multiplier; the product register loads only while en is high.
module q15_16_mul
  import mac_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [PROD_W-1:0] p
);
  logic signed [PROD_W-1:0] p_q, p_d;
  always_comb p_d = en ? PROD_W'(a) * PROD_W'(x) : p_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) p_q <= '0;
    else      p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/multiply_accumulate.sv
// multiply_accumulate: Y = A*X + B on signed Q15.16 behind a start/valid/done handshake.
// Define MAC_SATURATE_EN to clamp out-of-range results instead of wrapping modulo 2^32.
module multiply_accumulate
  import mac_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_in,
  input  logic              Done_in,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] X_in,
  input  logic [DATA_W-1:0] B_in,
  output logic [DATA_W-1:0] Y_out,
  output logic              Valid_out
);
`ifdef MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic signed [DATA_W-1:0] a_q, a_d, x_q, x_d, b_q, b_d;
  logic [DATA_W-1:0] y_q, y_d, y_res;
  logic valid_q, valid_d, cap, ovf;
  logic signed [PROD_W-1:0] p, s;
  q15_16_mul u_mul (
    .CLK(CLK),
    .RST(RST),
    .en (state_q == MUL),
    .a  (a_q),
    .x  (x_q),
    .p  (p)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (Start_in ? MUL : IDLE) :
              state_q == MUL  ? ADD :
              state_q == ADD  ? DONE :
              (Done_in ? IDLE : DONE);
  // The result fits in 32 bits only when bits 63..31 of the sum are all sign copies.
  assign s     = (p >>> FRAC_W) + PROD_W'(b_q);
  assign ovf   = !(&s[PROD_W-1:DATA_W-1] || ~|s[PROD_W-1:DATA_W-1]);
  assign y_res = (SAT_EN && ovf) ? (s[PROD_W-1] ? Q_MIN : Q_MAX) : s[DATA_W-1:0];
  always_comb begin
    cap     = state_q == IDLE && Start_in;
    a_d     = cap ? A_in : a_q;
    x_d     = cap ? X_in : x_q;
    b_d     = cap ? B_in : b_q;
    y_d     = state_q == ADD ? y_res : y_q;
    valid_d = state_q == ADD ? 1'b1 : (state_q == DONE && Done_in) ? 1'b0 : valid_q;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      a_q     <= '0;
      x_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      x_q     <= x_d;
      b_q     <= b_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  assign Y_out     = y_q;
  assign Valid_out = valid_q;
endmodule

// File: tb/tb_multiply_accumulate.sv
// tb_multiply_accumulate: directed checks of results, latency, handshake, reset abort and overflow handling.
module tb_multiply_accumulate;
  logic CLK, RST, Start_in, Done_in, Valid_out;
  logic [31:0] A_in, X_in, B_in, Y_out;
  int errors = 0;
  int checks = 0;
  multiply_accumulate dut (
    .CLK      (CLK),
    .RST      (RST),
    .Start_in (Start_in),
    .Done_in  (Done_in),
    .A_in     (A_in),
    .X_in     (X_in),
    .B_in     (B_in),
    .Y_out    (Y_out),
    .Valid_out(Valid_out)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [31:0] a, input logic [31:0] x, input logic [31:0] b);
    A_in = a;
    X_in = x;
    B_in = b;
    Start_in = 1'b1;
    @(negedge CLK);
    Start_in = 1'b0;
    A_in = $urandom;
    X_in = $urandom;
    B_in = $urandom;
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] x,
                     input logic [31:0] b, input logic [31:0] exp);
    start_op(a, x, b);
    chk({tag, "_v_cap"}, 32'(Valid_out), 32'd0);
    @(negedge CLK);
    chk({tag, "_v_mul"}, 32'(Valid_out), 32'd0);
    @(negedge CLK);
    chk({tag, "_v"}, 32'(Valid_out), 32'd1);
    chk({tag, "_y"}, Y_out, exp);
    Done_in = 1'b1;
    @(negedge CLK);
    Done_in = 1'b0;
    chk({tag, "_v_done"}, 32'(Valid_out), 32'd0);
    chk({tag, "_y_kept"}, Y_out, exp);
  endtask
  initial begin
    RST = 1'b0;
    Start_in = 1'b0;
    Done_in = 1'b0;
    A_in = '0;
    X_in = '0;
    B_in = '0;
    #12;
    chk("rst_y", Y_out, 32'h0);
    chk("rst_v", 32'(Valid_out), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_v", 32'(Valid_out), 32'd0);
    // Basic op with Start held through MUL and operands corrupted after capture.
    A_in = 32'h0001_8000;
    X_in = 32'h0002_4000;
    B_in = 32'h0000_C000;
    Start_in = 1'b1;
    @(negedge CLK);
    A_in = 32'h1234_5678;
    X_in = 32'h0BAD_0000;
    B_in = 32'h7777_7777;
    chk("basic_v_cap", 32'(Valid_out), 32'd0);
    @(negedge CLK);
    Start_in = 1'b0;
    chk("basic_v_mul", 32'(Valid_out), 32'd0);
    @(negedge CLK);
    chk("basic_v", 32'(Valid_out), 32'd1);
    chk("basic_y", Y_out, 32'h0004_2000);
    for (int i = 0; i < 10; i++) begin
      Start_in = (i == 3);
      @(negedge CLK);
      chk("hold_v", 32'(Valid_out), 32'd1);
      chk("hold_y", Y_out, 32'h0004_2000);
    end
    Start_in = 1'b0;
    Done_in = 1'b1;
    @(negedge CLK);
    Done_in = 1'b0;
    chk("ack_v", 32'(Valid_out), 32'd0);
    chk("ack_y", Y_out, 32'h0004_2000);
    repeat (3) @(negedge CLK);
    chk("no_queue_v", 32'(Valid_out), 32'd0);
    chk("no_queue_y", Y_out, 32'h0004_2000);
    run("neg1", 32'hFFFF_0000, 32'h0003_0000, 32'h0001_4000, 32'hFFFE_4000);
    run("negneg", 32'hFFFE_0000, 32'hFFFE_8000, 32'h0000_4000, 32'h0003_4000);
    run("zero", 32'h0000_0000, 32'h0005_8000, 32'h0002_0000, 32'h0002_0000);
`ifdef MAC_SATURATE_EN
    run("ovf_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h0, 32'h7FFF_FFFF);
    run("ovf_neg", 32'h8000_0000, 32'h0002_0000, 32'h0, 32'h8000_0000);
`else
    run("ovf_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h0, 32'hFFFE_0000);
    run("ovf_neg", 32'h8000_0000, 32'h0002_0000, 32'h0, 32'h0000_0000);
`endif
    run("pre_rst", 32'h0001_0000, 32'h0003_0000, 32'h0, 32'h0003_0000);
    // Abort while in ADD.
    start_op(32'h0001_8000, 32'h0002_4000, 32'h0000_C000);
    @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("arst_v", 32'(Valid_out), 32'd0);
    chk("arst_y", Y_out, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_v", 32'(Valid_out), 32'd0);
    chk("abort_y", Y_out, 32'h0);
    run("post_rst", 32'h0001_8000, 32'h0002_4000, 32'h0000_C000, 32'h0004_2000);
    // Start and Done together in DONE: Done wins, Start accepted one cycle later.
    start_op(32'hFFFF_0000, 32'h0003_0000, 32'h0001_4000);
    repeat (2) @(negedge CLK);
    chk("sim_pre_v", 32'(Valid_out), 32'd1);
    chk("sim_pre_y", Y_out, 32'hFFFE_4000);
    A_in = 32'h0001_8000;
    X_in = 32'h0002_4000;
    B_in = 32'h0000_C000;
    Start_in = 1'b1;
    Done_in = 1'b1;
    @(negedge CLK);
    Done_in = 1'b0;
    chk("sim_v_m", 32'(Valid_out), 32'd0);
    chk("sim_y_m", Y_out, 32'hFFFE_4000);
    @(negedge CLK);
    Start_in = 1'b0;
    chk("sim_v_cap", 32'(Valid_out), 32'd0);
    @(negedge CLK);
    chk("sim_v_mul", 32'(Valid_out), 32'd0);
    @(negedge CLK);
    chk("sim_v", 32'(Valid_out), 32'd1);
    chk("sim_y", Y_out, 32'h0004_2000);
    Done_in = 1'b1;
    @(negedge CLK);
    Done_in = 1'b0;
    chk("sim_v_done", 32'(Valid_out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
